// File: rtl/ofdm_frame_pkg.sv
// Shared definitions for the OFDM frame scheduler: carrier kinds, FSM encodings, FIFO entry layout.
package ofdm_frame_pkg;

  localparam logic [1:0] KIND_DATA  = 2'b00;
  localparam logic [1:0] KIND_PILOT = 2'b01;
  localparam logic [1:0] KIND_NULL  = 2'b10;
  localparam logic [1:0] KIND_PRE   = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_PRE   = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;
  localparam logic [1:0] ST_DRAIN = 2'b11;

  localparam int ENTRY_W = 5;

  typedef struct packed {
    logic [1:0] data;
    logic [1:0] kind;
    logic       sym_start;
  } carrier_t;

  function automatic carrier_t make_carrier(input logic [1:0] data, input logic [1:0] kind,
                                            input logic sos);
    carrier_t c;
    c.data      = data;
    c.kind      = kind;
    c.sym_start = sos;
    return c;
  endfunction

endpackage

// File: rtl/sched_skid_fifo.sv
// Two-entry output FIFO for the frame scheduler. Port a is always the older of two same-cycle
// writes (a returning ROM read), port b the newer (a pilot/null issued in the same cycle).
module sched_skid_fifo #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_a,
  input  logic [W-1:0] din_a,
  input  logic         push_b,
  input  logic [W-1:0] din_b,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] e0_r;
  logic [W-1:0] e1_r;
  logic [1:0]   count_r;

  logic         pop_s;
  logic [1:0]   base_cnt_s;
  logic [1:0]   idx_a_s;
  logic [1:0]   idx_b_s;
  logic [1:0]   cnt_next_s;
  logic [W-1:0] base_s [0:1];
  logic [W-1:0] slot_s [0:1];

  // Shift out the head on pop, then append the ordered writes behind the survivors.
  always_comb begin
    pop_s      = pop && (count_r != 2'd0);
    base_cnt_s = count_r - {1'b0, pop_s};
    idx_a_s    = base_cnt_s;
    idx_b_s    = base_cnt_s + {1'b0, push_a};
    cnt_next_s = base_cnt_s + {1'b0, push_a} + {1'b0, push_b};
    base_s[0]  = pop_s ? e1_r : e0_r;
    base_s[1]  = pop_s ? {W{1'b0}} : e1_r;
    for (int i = 0; i < 2; i++) begin
      if (push_a && (idx_a_s == 2'(i))) begin
        slot_s[i] = din_a;
      end else if (push_b && (idx_b_s == 2'(i))) begin
        slot_s[i] = din_b;
      end else begin
        slot_s[i] = base_s[i];
      end
    end
  end

  // Entry storage; empty slots are kept at zero so the head reads 0 when nothing is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_r    <= {W{1'b0}};
      e1_r    <= {W{1'b0}};
      count_r <= 2'd0;
    end else begin
      e0_r    <= slot_s[0];
      e1_r    <= slot_s[1];
      count_r <= cnt_next_s;
    end
  end

  assign head  = e0_r;
  assign count = count_r;

endmodule

// File: rtl/ofdm_frame_sched.sv
// OFDM frame scheduler: turns ROM bit-pairs into symbols with guard, DC and pilot carriers.
// Define FRAME_PREAMBLE_EN to prepend one preamble symbol to every frame.
module ofdm_frame_sched
  import ofdm_frame_pkg::*;
#(
  parameter int         ADDR_W         = 10,
  parameter int         N_SC           = 64,
  parameter int         N_NULL_LO      = 6,
  parameter int         N_NULL_HI      = 5,
  parameter int         PILOT_SPACING  = 8,
  parameter logic [1:0] PILOT_VAL      = 2'b11,
  parameter int         SYMS_PER_FRAME = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [1:0]        rom_data,
  output logic [1:0]        out_data,
  output logic [1:0]        out_kind,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sym_start,
  output logic              frame_done,
  output logic              busy
);

  localparam int K_W   = $clog2(N_SC);
  localparam int SYM_W = $clog2(SYMS_PER_FRAME + 1);
  localparam int PC_W  = $clog2(PILOT_SPACING + 1);

  localparam logic [K_W-1:0]   K_ZERO    = {K_W{1'b0}};
  localparam logic [K_W-1:0]   K_LAST    = K_W'(N_SC - 1);
  localparam logic [K_W-1:0]   K_LO      = K_W'(N_NULL_LO);
  localparam logic [K_W-1:0]   K_HI      = K_W'(N_SC - N_NULL_HI);
  localparam logic [K_W-1:0]   K_DC      = K_W'(N_SC / 2);
  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SYMS_PER_FRAME - 1);
  localparam logic [PC_W-1:0]  PC_ZERO   = {PC_W{1'b0}};
  localparam logic [PC_W-1:0]  PC_RELOAD = PC_W'(PILOT_SPACING - 1);

`ifdef FRAME_PREAMBLE_EN
  localparam logic [1:0] FIRST_ST = ST_PRE;
`else
  localparam logic [1:0] FIRST_ST = ST_RUN;
`endif

  logic [1:0]        state_r;
  logic [K_W-1:0]    k_r;
  logic [SYM_W-1:0]  sym_r;
  logic [PC_W-1:0]   pcnt_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic              inflight_r;
  logic              inflight_sos_r;
  logic              frame_done_r;
  logic              busy_r;

  logic              null_s;
  logic              pilot_s;
  logic              pre_s;
  logic              data_s;
  logic              k_last_s;
  logic              sos_s;
  logic [PC_W-1:0]   pcnt_next_s;
  logic              active_s;
  logic              room_s;
  logic              issue_s;
  logic              rom_rd_s;
  logic              push_b_s;
  logic              pop_s;
  logic              last_pop_s;
  logic [1:0]        count_s;
  carrier_t          issue_entry_s;
  carrier_t          data_entry_s;
  carrier_t          head_s;

  // Classify carrier k; pilots come from a down-counter that restarts at the first non-guard carrier.
  always_comb begin
    null_s   = (k_r < K_LO) || (k_r >= K_HI) || (k_r == K_DC);
    pilot_s  = !null_s && (pcnt_r == PC_ZERO);
    pre_s    = (state_r == ST_PRE);
    data_s   = !null_s && !pilot_s && !pre_s;
    k_last_s = (k_r == K_LAST);
    sos_s    = (k_r == K_ZERO);
    if (k_last_s || (k_r < K_LO)) begin
      pcnt_next_s = PC_ZERO;
    end else if (pcnt_r == PC_ZERO) begin
      pcnt_next_s = PC_RELOAD;
    end else begin
      pcnt_next_s = pcnt_r - PC_W'(1);
    end
  end

  // Issue gating: an in-flight ROM read reserves a FIFO slot just like a stored entry.
  always_comb begin
    active_s   = (state_r == ST_RUN) || (state_r == ST_PRE);
    room_s     = ({1'b0, count_s} + {2'b00, inflight_r}) < 3'd2;
    issue_s    = active_s && en && room_s;
    rom_rd_s   = issue_s && data_s;
    push_b_s   = issue_s && !data_s;
    pop_s      = (count_s != 2'd0) && out_ready;
    last_pop_s = (state_r == ST_DRAIN) && pop_s && (count_s == 2'd1) && !inflight_r;
    data_entry_s = make_carrier(rom_data, KIND_DATA, inflight_sos_r);
    if (null_s) begin
      issue_entry_s = make_carrier(2'b00, KIND_NULL, sos_s);
    end else if (pre_s) begin
      issue_entry_s = make_carrier(PILOT_VAL, KIND_PRE, sos_s);
    end else begin
      issue_entry_s = make_carrier(PILOT_VAL, KIND_PILOT, sos_s);
    end
  end

  sched_skid_fifo #(
    .W(ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push_a(inflight_r),
    .din_a (data_entry_s),
    .push_b(push_b_s),
    .din_b (issue_entry_s),
    .pop   (pop_s),
    .head  (head_s),
    .count (count_s)
  );

  // Frame FSM, carrier/symbol counters and the free-running ROM address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      k_r            <= K_ZERO;
      sym_r          <= {SYM_W{1'b0}};
      pcnt_r         <= PC_ZERO;
      rom_addr_r     <= {ADDR_W{1'b0}};
      inflight_r     <= 1'b0;
      inflight_sos_r <= 1'b0;
      frame_done_r   <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      frame_done_r   <= 1'b0;
      inflight_r     <= rom_rd_s;
      inflight_sos_r <= rom_rd_s && sos_s;
      if (rom_rd_s) begin
        rom_addr_r <= rom_addr_r + ADDR_W'(1);
      end
      if (issue_s) begin
        k_r    <= k_last_s ? K_ZERO : (k_r + K_W'(1));
        pcnt_r <= pcnt_next_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= FIRST_ST;
            k_r     <= K_ZERO;
            sym_r   <= {SYM_W{1'b0}};
            pcnt_r  <= PC_ZERO;
            busy_r  <= 1'b1;
          end
        end
        ST_PRE: begin
          if (issue_s && k_last_s) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue_s && k_last_s) begin
            if (sym_r == SYM_LAST) begin
              state_r <= ST_DRAIN;
            end else begin
              sym_r <= sym_r + SYM_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (last_pop_s) begin
            state_r      <= ST_IDLE;
            frame_done_r <= 1'b1;
            busy_r       <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_addr   = rom_addr_r;
  assign rom_rd     = rom_rd_s;
  assign out_data   = head_s.data;
  assign out_kind   = head_s.kind;
  assign sym_start  = head_s.sym_start;
  assign out_valid  = (count_s != 2'd0);
  assign frame_done = frame_done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ofdm_frame_sched.sv
// Scoreboard bench for ofdm_frame_sched: expected carriers are queued at stimulus time and a
// monitor thread pops and compares every accepted beat.
module tb_ofdm_frame_sched;

`ifdef FRAME_PREAMBLE_EN
  localparam int PRE_SYMS = 1;
`else
  localparam int PRE_SYMS = 0;
`endif
  localparam int PRE_OFF = PRE_SYMS * 64;

  logic       clk;
  logic       rst;
  logic       en;
  logic       start;
  logic [9:0] rom_addr;
  logic       rom_rd;
  logic [1:0] rom_data = 2'b00;
  logic [1:0] out_data;
  logic [1:0] out_kind;
  logic       out_valid;
  logic       out_ready;
  logic       sym_start;
  logic       frame_done;
  logic       busy;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int beat_total = 0;
  int rd_total = 0;
  int fd_cnt = 0;
  int frame_base = 0;
  int model_addr = 0;
  bit bp_mode = 1'b0;
  logic [4:0] exp_q[$];
  logic [4:0] cap [0:127];

  ofdm_frame_sched dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_rd    (rom_rd),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_kind  (out_kind),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sym_start (sym_start),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] rom_fn(input logic [9:0] a);
    return a[1:0] ^ a[9:8] ^ 2'b01;
  endfunction

  // Synchronous ROM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom_fn(rom_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic expect_frame();
    logic [1:0] d;
    logic [1:0] kd;
    for (int s = 0; s < PRE_SYMS + 4; s++) begin
      for (int k = 0; k < 64; k++) begin
        if (k < 6 || k >= 59 || k == 32) begin
          d = 2'b00; kd = 2'b10;
        end else if (s < PRE_SYMS) begin
          d = 2'b11; kd = 2'b11;
        end else if ((k - 6) % 8 == 0) begin
          d = 2'b11; kd = 2'b01;
        end else begin
          d = rom_fn(10'(model_addr)); kd = 2'b00;
          model_addr = (model_addr + 1) % 1024;
        end
        exp_q.push_back({d, kd, (k == 0)});
      end
    end
  endtask

  task automatic monitor();
    logic [4:0] got;
    logic [4:0] held;
    logic [4:0] exp;
    bit hold_pend;
    bit prev_acc;
    int idx;
    hold_pend = 1'b0;
    prev_acc = 1'b0;
    held = 5'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
        prev_acc = 1'b0;
      end else begin
        got = {out_data, out_kind, sym_start};
        if (hold_pend) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_stable", 32'(got), 32'(held));
        end
        if (rom_rd) begin
          if (rd_total == 1023) check("wrap_last_addr", 32'(rom_addr), 32'd1023);
          if (rd_total == 1024) check("wrap_zero_addr", 32'(rom_addr), 32'd0);
          rd_total++;
        end
        if (frame_done) begin
          check("fd_after_last_beat", 32'(prev_acc), 32'd1);
          check("fd_queue_empty", 32'(exp_q.size()), 32'd0);
          fd_cnt++;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL beat_extra: actual %0h required none", got);
          end else begin
            exp = exp_q.pop_front();
            check("beat", 32'(got), 32'(exp));
          end
          idx = beat_total - frame_base;
          if (idx >= 0 && idx < 128) cap[idx] = got;
          beat_total++;
        end
        prev_acc = out_valid && out_ready;
        hold_pend = out_valid && !out_ready;
        held = got;
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    frame_base = beat_total;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (frame_done === 1'b1) pass_cnt++;
    else $display("FAIL %s_timeout: actual frame_done=%b required 1 within 4000 cycles", tag, frame_done);
    @(posedge clk);
    #1;
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_beats(input int nb);
    int n;
    n = 0;
    while ((beat_total - frame_base) < nb && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if ((beat_total - frame_base) >= nb) pass_cnt++;
    else $display("FAIL wait_beats_timeout: actual %0d required %0d", beat_total - frame_base, nb);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_rom_rd"}, 32'(rom_rd), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_kind"}, 32'(out_kind), 32'd0);
    check({tag, "_sym_start"}, 32'(sym_start), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int r0;
    int b0;
    int fd0;
    rst = 1'b1;
    en = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    fork
      monitor();
      ready_driver();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full frame with out_ready high, plus start latency and classification spot checks.
    r0 = rd_total;
    expect_frame();
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    check("latency_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_2", 32'(out_valid), 32'd1);
    wait_done("frame1");
    check("frame1_reads", 32'(rd_total - r0), 32'd180);
    check("frame1_rom_addr", 32'(rom_addr), 32'd180);
    check("k0_null_sos", 32'(cap[PRE_OFF + 0]), 32'b00101);
    check("k5_null", 32'(cap[PRE_OFF + 5]), 32'b00100);
    check("k6_pilot", 32'(cap[PRE_OFF + 6]), 32'b11010);
    check("k7_rom0", 32'(cap[PRE_OFF + 7]), 32'b01000);
    check("k8_rom1", 32'(cap[PRE_OFF + 8]), 32'b00000);
    check("k9_rom2", 32'(cap[PRE_OFF + 9]), 32'b11000);
    check("k32_dc_null", 32'(cap[PRE_OFF + 32]), 32'b00100);
    check("k59_null", 32'(cap[PRE_OFF + 59]), 32'b00100);
    check("k63_null", 32'(cap[PRE_OFF + 63]), 32'b00100);
`ifdef FRAME_PREAMBLE_EN
    check("pre_k6", 32'(cap[6]), 32'b11110);
    check("frame1_beats", 32'(beat_total - frame_base), 32'd320);
`else
    check("frame1_beats", 32'(beat_total - frame_base), 32'd256);
`endif

    // Start while busy must be ignored: the frame below still ends after exactly one frame.
    // Random backpressure; the monitor also verifies held beats do not change.
    bp_mode = 1'b1;
    expect_frame();
    do_start();
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("frame_bp");
    bp_mode = 1'b0;
    check("frame_bp_rom_addr", 32'(rom_addr), 32'd360);

    // en low for 10 cycles mid-symbol.
    expect_frame();
    do_start();
    wait_beats(PRE_OFF + 70);
    en = 1'b0;
    b0 = beat_total;
    r0 = rd_total;
    repeat (10) @(posedge clk);
    #1;
    check("pause_no_reads", 32'(rd_total - r0), 32'd0);
    check("pause_max_2_beats", 32'((beat_total - b0) <= 2), 32'd1);
    en = 1'b1;
    wait_done("frame_pause");
    check("frame_pause_rom_addr", 32'(rom_addr), 32'd540);

    // Three more frames take the read count past 1024 so the address wraps.
    for (int f = 0; f < 3; f++) begin
      expect_frame();
      do_start();
      wait_done("frame_wrap");
    end
    check("wrap_rom_addr", 32'(rom_addr), 32'd56);
    check("wrap_total_reads", 32'(rd_total), 32'd1080);

    // Reset mid-frame aborts with no frame_done; a new frame afterwards runs normally.
    expect_frame();
    do_start();
    wait_beats(100);
    fd0 = fd_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    model_addr = 0;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_frame_done", 32'(fd_cnt), 32'(fd0));
    check("midrst_idle_valid", 32'(out_valid), 32'd0);
    expect_frame();
    do_start();
    wait_done("frame_after_rst");
    check("after_rst_rom_addr", 32'(rom_addr), 32'd180);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
